// File: rtl/pc_gen_unit.sv
// Program-counter generation stage: holds the fetch PC, picks the next PC by
// redirect priority, rejects misaligned branch/JALR targets and predicts returns.
module pc_gen_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_target_i,
  input  logic            br_taken_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] br_base_i,
  input  logic [XLEN-1:0] br_offset_i,
  input  logic            call_i,
  input  logic [XLEN-1:0] ret_addr_i,
  input  logic            ret_pred_i,
  output logic [XLEN-1:0] PC_o,
  output logic [XLEN-1:0] PC_NXT_o,
  output logic            valid_o,
  output logic            misalign_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];

  logic [XLEN-1:0] tgt_sum, jalr_tgt, ras_top;
  logic [PW-1:0]   top_idx, wr_idx;
  logic            ras_empty, ras_full, ras_upd, push, pop;

  assign tgt_sum   = br_base_i + br_offset_i;
  assign jalr_tgt  = {tgt_sum[XLEN-1:1], 1'b0};
  assign top_idx   = ptr_q - PW'(1);
  assign ras_top   = ras_mem_q[top_idx];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_upd   = !stall_i && !flush_i;

  always_comb begin
    pc_d       = pc_q;
    valid_d    = 1'b1;
    misalign_d = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    // The edge that raises valid only arms fetch; RESET_VECTOR is fetched first.
    if (valid_q) begin
      if (flush_i) begin
        pc_d = {flush_target_i[XLEN-1:2], 2'b00};
      end else if (jalr_i) begin
        if (jalr_tgt[1]) misalign_d = 1'b1;
        else             pc_d       = jalr_tgt;
      end else if (br_taken_i) begin
        if (tgt_sum[1]) misalign_d = 1'b1;
        else            pc_d       = tgt_sum;
      end else if (ret_pred_i && !ras_empty && !stall_i) begin
        pc_d = ras_top;
      end else if (!stall_i) begin
        pc_d = pc_q + XLEN'(INC);
      end
      push = ras_upd && !misalign_d && call_i;
      pop  = ras_upd && !misalign_d && ret_pred_i && !ras_empty;
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_idx = ptr_q;
    if (push && pop) begin
      wr_idx = top_idx;
    end else if (push) begin
      // On a full stack the write slot is the oldest entry, which is overwritten.
      ptr_d = ptr_q + PW'(1);
      cnt_d = ras_full ? cnt_q : cnt_q + CW'(1);
    end else if (pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem_q[wr_idx] <= ret_addr_i;
  end

  assign PC_o        = pc_q;
  assign PC_NXT_o    = pc_d;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed steps followed by random traffic, every cycle
// compared against a queue-based reference model of the PC and return stack.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, br_taken_i, jalr_i, call_i, ret_pred_i;
  logic [31:0] flush_target_i, br_base_i, br_offset_i, ret_addr_i;
  logic [31:0] PC_o, PC_NXT_o;
  logic        valid_o, misalign_o, ras_empty_o, ras_full_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_valid, m_mis;
  logic [31:0] m_ras[$];

  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .flush_target_i(flush_target_i), .br_taken_i(br_taken_i), .jalr_i(jalr_i),
    .br_base_i(br_base_i), .br_offset_i(br_offset_i), .call_i(call_i),
    .ret_addr_i(ret_addr_i), .ret_pred_i(ret_pred_i), .PC_o(PC_o),
    .PC_NXT_o(PC_NXT_o), .valid_o(valid_o), .misalign_o(misalign_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall_i = 0; flush_i = 0; br_taken_i = 0; jalr_i = 0; call_i = 0; ret_pred_i = 0;
    flush_target_i = 0; br_base_i = 0; br_offset_i = 0; ret_addr_i = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 0; m_mis = 0;
    m_ras.delete();
  endtask

  // Next PC and misalign decision straight from the redirect priority rules.
  task automatic model_next(output logic [31:0] nxt, output logic mis);
    logic [31:0] sum, jt;
    sum = br_base_i + br_offset_i;
    jt  = sum & 32'hFFFF_FFFE;
    nxt = m_pc;
    mis = 0;
    if (m_valid) begin
      if (flush_i)                                       nxt = flush_target_i & 32'hFFFF_FFFC;
      else if (jalr_i)     begin if (jt[1])  mis = 1; else nxt = jt;  end
      else if (br_taken_i) begin if (sum[1]) mis = 1; else nxt = sum; end
      else if (ret_pred_i && m_ras.size() > 0 && !stall_i) nxt = m_ras[m_ras.size()-1];
      else if (!stall_i)                                 nxt = m_pc + 32'd4;
    end
  endtask

  task automatic model_commit(input logic [31:0] nxt, input logic mis);
    bit popping;
    if (m_valid && !stall_i && !flush_i && !mis) begin
      popping = ret_pred_i && m_ras.size() > 0;
      if (call_i && popping) m_ras[m_ras.size()-1] = ret_addr_i;
      else if (call_i) begin
        m_ras.push_back(ret_addr_i);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (popping) void'(m_ras.pop_back());
    end
    m_mis   = m_valid ? mis : 1'b0;
    m_pc    = nxt;
    m_valid = 1;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string tag);
    logic [31:0] nxt;
    logic        mis;
    #1;
    model_next(nxt, mis);
    chk({tag, ".nxt"}, PC_NXT_o, nxt);
    @(posedge clk);
    model_commit(nxt, mis);
    #1;
    chk({tag, ".pc"},    PC_o, m_pc);
    chk({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
    chk({tag, ".mis"},   32'(misalign_o), 32'(m_mis));
    chk({tag, ".empty"}, 32'(ras_empty_o), 32'(m_ras.size() == 0));
    chk({tag, ".full"},  32'(ras_full_o), 32'(m_ras.size() == 4));
    @(negedge clk);
  endtask

  initial begin
    int o;
    idle();
    rst = 1;
    model_reset();
    #1;
    chk("rst0.pc", PC_o, 32'h0);
    chk("rst0.valid", 32'(valid_o), 32'h0);
    chk("rst0.empty", 32'(ras_empty_o), 32'h1);
    chk("rst0.full", 32'(ras_full_o), 32'h0);
    @(negedge clk);
    rst = 0;
    cycle("arm");  chk("arm.pc0", PC_o, 32'h0); chk("arm.v", 32'(valid_o), 32'h1);
    cycle("seq1"); chk("seq1.c", PC_o, 32'h4);

    // mid-run asynchronous reset from PC 0x40
    flush_i = 1; flush_target_i = 32'h40; cycle("fl40"); idle();
    chk("fl40.c", PC_o, 32'h40);
    #2; rst = 1; #1;
    model_reset();
    chk("arst.pc", PC_o, 32'h0);
    chk("arst.valid", 32'(valid_o), 32'h0);
    @(negedge clk); rst = 0;
    cycle("rel");  chk("rel.c", PC_o, 32'h0); chk("rel.v", 32'(valid_o), 32'h1);
    cycle("s4");   chk("s4.c", PC_o, 32'h4);
    cycle("s8");   chk("s8.c", PC_o, 32'h8);

    // branch / JALR / both
    br_taken_i = 1; br_base_i = 32'h100; br_offset_i = 32'hFFFF_FFF0; cycle("br"); idle();
    chk("br.c", PC_o, 32'hF0);
    jalr_i = 1; br_base_i = 32'h201; br_offset_i = 32'h4; cycle("jalr"); idle();
    chk("jalr.c", PC_o, 32'h204);
    jalr_i = 1; br_taken_i = 1; br_base_i = 32'h300; br_offset_i = 32'h1; cycle("both"); idle();
    chk("both.c", PC_o, 32'h300);

    // misalignment and stall
    br_taken_i = 1; br_base_i = 32'h100; br_offset_i = 32'h2; cycle("mis"); idle();
    chk("mis.c", PC_o, 32'h300); chk("mis.m", 32'(misalign_o), 32'h1);
    cycle("mis2"); chk("mis2.c", PC_o, 32'h304); chk("mis2.m", 32'(misalign_o), 32'h0);
    stall_i = 1; cycle("stall"); chk("stall.c", PC_o, 32'h304);
    flush_i = 1; flush_target_i = 32'h80; cycle("stfl"); idle();
    chk("stfl.c", PC_o, 32'h80);
    flush_i = 1; flush_target_i = 32'h87; cycle("flal"); idle();
    chk("flal.c", PC_o, 32'h84);
    jalr_i = 1; br_base_i = 32'h41; br_offset_i = 32'h1; cycle("jmis"); idle();
    chk("jmis.c", PC_o, 32'h84); chk("jmis.m", 32'(misalign_o), 32'h1);

    // basic RAS
    for (int i = 1; i <= 3; i++) begin
      call_i = 1; ret_addr_i = 32'(i * 16); cycle("push"); idle();
    end
    for (int i = 3; i >= 1; i--) begin
      ret_pred_i = 1; cycle("pop"); idle();
      chk("pop.c", PC_o, 32'(i * 16));
    end
    chk("pop.empty", 32'(ras_empty_o), 32'h1);
    ret_pred_i = 1; cycle("pope"); idle();
    chk("pope.c", PC_o, 32'h14);

    // overflow: A..E pushed, A lost
    for (int i = 1; i <= 5; i++) begin
      call_i = 1; ret_addr_i = 32'(i * 32'h1000); cycle("ovf"); idle();
    end
    chk("ovf.full", 32'(ras_full_o), 32'h1);
    for (int i = 5; i >= 2; i--) begin
      ret_pred_i = 1; cycle("opop"); idle();
      chk("opop.c", PC_o, 32'(i * 32'h1000));
    end
    chk("opop.empty", 32'(ras_empty_o), 32'h1);
    ret_pred_i = 1; cycle("opope"); idle();
    chk("opope.c", PC_o, 32'h2004);

    // wrap, simultaneous push/pop, stall-gated pop, misaligned redirect leaves RAS alone
    flush_i = 1; flush_target_i = 32'hFFFF_FFFC; cycle("wfl"); idle();
    cycle("wrap"); chk("wrap.c", PC_o, 32'h0);
    call_i = 1; ret_addr_i = 32'h30; cycle("p30"); idle();
    call_i = 1; ret_pred_i = 1; ret_addr_i = 32'h990; cycle("pp"); idle();
    chk("pp.c", PC_o, 32'h30); chk("pp.empty", 32'(ras_empty_o), 32'h0);
    call_i = 1; ret_addr_i = 32'h40; cycle("p40"); idle();
    ret_pred_i = 1; stall_i = 1; cycle("rst_st"); idle();
    chk("rst_st.c", PC_o, 32'h34);
    ret_pred_i = 1; cycle("r40"); idle(); chk("r40.c", PC_o, 32'h40);
    ret_pred_i = 1; cycle("r990"); idle(); chk("r990.c", PC_o, 32'h990);
    call_i = 1; ret_addr_i = 32'h500; br_taken_i = 1; br_base_i = 32'h40; br_offset_i = 32'h2;
    cycle("cmis"); idle();
    chk("cmis.empty", 32'(ras_empty_o), 32'h1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      flush_i    = ($urandom_range(0, 15) == 0);
      jalr_i     = ($urandom_range(0, 9) == 0);
      br_taken_i = ($urandom_range(0, 7) == 0);
      call_i     = ($urandom_range(0, 4) == 0);
      ret_pred_i = ($urandom_range(0, 4) == 0);
      stall_i    = ($urandom_range(0, 4) == 0);
      flush_target_i = $urandom;
      br_base_i  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) br_base_i = br_base_i | 32'($urandom_range(0, 3));
      o = int'($urandom_range(0, 2047)) - 1024;
      br_offset_i = 32'(o) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) br_offset_i = br_offset_i | 32'($urandom_range(0, 3));
      ret_addr_i = $urandom & 32'hFFFF_FFFC;
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generation stage for the pipelined RV32I core.
- Holds the architectural fetch PC and computes the next PC from the sequential increment, resolved branch/JAL targets (base + offset), JALR targets (bit 0 cleared), or a flush/trap vector.
- Adds stall handling, misaligned-target detection and a small return-address stack (RAS) for return prediction.
- Feeds the instruction-memory address and the IF/ID pipeline register.

Parameters:
XLEN, 32, datapath and PC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
INC, 4, sequential PC increment in bytes
RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
stall_i  input  1  hold PC; gates RAS push/pop
flush_i  input  1  redirect to flush_target_i (trap/exception), highest priority
flush_target_i  input  XLEN  flush/trap vector
br_taken_i  input  1  resolved branch/JAL taken; target = br_base_i + br_offset_i
jalr_i  input  1  resolved JALR; target = (br_base_i + br_offset_i) & ~1
br_base_i  input  XLEN  target base (PC or rs1)
br_offset_i  input  XLEN  sign-extended immediate
call_i  input  1  push ret_addr_i onto RAS
ret_addr_i  input  XLEN  return address for push
ret_pred_i  input  1  predicted return; pop RAS and redirect to popped value
PC_o  output  XLEN  registered current fetch PC
PC_NXT_o  output  XLEN  combinational next-PC value
valid_o  output  1  PC_o holds a fetchable address
misalign_o  output  1  registered one-cycle pulse: redirect target rejected as misaligned
ras_empty_o  output  1  RAS occupancy == 0
ras_full_o  output  1  RAS occupancy == RAS_DEPTH

Behaviour:
- Reset (asynchronous, any time, including mid-redirect): PC_o = RESET_VECTOR, valid_o = 0, misalign_o = 0, RAS pointer and count = 0, ras_empty_o = 1, ras_full_o = 0.
- valid_o rises on the first clock edge after rst deasserts and stays high. The PC is not advanced on that edge; the first fetch is RESET_VECTOR.
- Target arithmetic: XLEN-bit modulo-2^XLEN addition. No carry out. Wrap from 0xFFFF_FFFC + 4 to 0x0000_0000 is legal.
- Next-PC priority, evaluated combinationally into PC_NXT_o, registered on each rising clk:
  1. flush_i: flush_target_i. Bits [1:0] are forced to 0; a flush is never rejected.
  2. jalr_i: (br_base_i + br_offset_i) with bit 0 cleared.
  3. br_taken_i: br_base_i + br_offset_i.
  4. ret_pred_i with RAS non-empty and stall_i = 0: RAS top entry.
  5. stall_i: PC_o (hold).
  6. Otherwise: PC_o + INC.
- Redirects 1–3 override stall_i.
- jalr_i and br_taken_i both high: JALR wins.
- Misalignment: a priority-2/3 target with bit 1 set is rejected.
  - PC_o holds.
  - misalign_o = 1 for exactly the following cycle.
  - RAS is unaffected.
- ret_pred_i with an empty RAS: no pop, no redirect; fall through to priorities 5/6.
- RAS is a circular LIFO and is updated only when stall_i = 0 and flush_i = 0:
  - Push on full: overwrite the oldest entry; count stays RAS_DEPTH.
  - Pop on empty: ignored.
  - Push and pop in the same cycle: the top entry is replaced by ret_addr_i, count unchanged, redirect uses the old top.
- Flush does not clear the RAS. Latency for every redirect is one cycle: target appears on PC_o after the next rising edge.

Test Plan:
- Reset: rst high mid-run, PC_o = 0x40 → PC_o = 0x0 immediately, valid_o = 0. Release → valid_o = 1 next edge. Then 0x0, 0x4, 0x8 on successive edges.
- Branch/JALR: br_taken_i, base 0x100, offset 0xFFFF_FFF0 → PC_o = 0xF0. jalr_i, base 0x201, offset 0x4 → PC_o = 0x204. Both asserted → JALR target.
- Misalign and stall: br_taken_i, target 0x102 → PC_o holds, misalign_o high one cycle. stall_i with no redirect → PC_o frozen. stall_i with flush_i, target 0x80 → PC_o = 0x80.
- RAS basic: push 0x10, 0x20, 0x30 → three ret_pred_i pops redirect to 0x30, 0x20, 0x10, then ras_empty_o = 1. Fourth ret_pred_i → sequential increment.
- RAS overflow: RAS_DEPTH = 4, push 5 values A..E → ras_full_o = 1. Pops return E, D, C, B; A is lost.
- Wrap and simultaneous ops: PC_o = 0xFFFF_FFFC → next PC_o = 0x0. call_i and ret_pred_i together with top = 0x30 → redirect to 0x30, new top = ret_addr_i, count unchanged.
